// File: rtl/sar_pkg.sv
// Shared types and width helpers for the SAR conversion controller.
package sar_pkg;

  // Controller phases: idle, track/hold, bit-by-bit search, result strobe.
  typedef enum logic [1:0] {
    StIdle,
    StSample,
    StConvert,
    StDone
  } sar_state_t;

  // Bits needed to count 0..v-1, never less than one so a counter always exists.
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // Counter widths for the default configuration (8 bits, 2 sample, 1 settle).
  localparam int unsigned DefSampleCntW = cnt_width(2);
  localparam int unsigned DefSettleCntW = cnt_width(1);
  localparam int unsigned DefBitIdxW    = cnt_width(8);

endpackage

// File: rtl/sar_logic.sv
// Successive-approximation controller: sample phase, MSB-first binary search
// driven through dac_code / comp_in, then a one-cycle done strobe with the result.
module sar_logic
  import sar_pkg::*;
#(
  parameter int unsigned DAC_BITS      = 8,
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                comp_in,
  output logic                sample,
  output logic                busy,
  output logic [DAC_BITS-1:0] dac_code,
  output logic [DAC_BITS-1:0] data_out,
  output logic                done
);

  localparam int unsigned SampleW = cnt_width(SAMPLE_CYCLES);
  localparam int unsigned SettleW = cnt_width(SETTLE_CYCLES);
  localparam int unsigned CntW    = (SampleW > SettleW) ? SampleW : SettleW;
  localparam int unsigned KW      = cnt_width(DAC_BITS);

  localparam logic [CntW-1:0] SampleLast = CntW'(SAMPLE_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [KW-1:0]   KTop       = KW'(DAC_BITS - 1);

  sar_state_t          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [KW-1:0]       k_q, k_d;
  logic [DAC_BITS-1:0] trial_q, trial_d;
  logic [DAC_BITS-1:0] data_q, data_d;
  logic                sample_q, sample_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state, trial register update and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    trial_d = trial_q;
    data_d  = data_q;

    unique case (state_q)
      StIdle: begin
        trial_d = '0;
        cnt_d   = '0;
        if (start) begin
          state_d = StSample;
        end
      end

      StSample: begin
        if (cnt_q == SampleLast) begin
          cnt_d               = '0;
          k_d                 = KTop;
          trial_d             = '0;
          trial_d[DAC_BITS-1] = 1'b1;
          state_d             = StConvert;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StConvert: begin
        // comp_in only matters on the edge that closes a settle phase.
        if (cnt_q == SettleLast) begin
          cnt_d = '0;
          if (!comp_in) begin
            trial_d[k_q] = 1'b0;
          end
          if (k_q != '0) begin
            k_d          = k_q - 1'b1;
            trial_d[k_d] = 1'b1;
          end else begin
            data_d  = trial_d;
            trial_d = '0;
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are decoded from the next state so they line up with it after the edge.
    sample_d = (state_d == StSample);
    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StDone);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      k_q      <= '0;
      trial_q  <= '0;
      data_q   <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      trial_q  <= trial_d;
      data_q   <= data_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // trial_q is held at zero outside CONVERT, so it doubles as the DAC code.
  assign dac_code = trial_q;
  assign data_out = data_q;
  assign sample   = sample_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sar_logic.sv
// Self-checking bench for sar_logic: ideal 8-bit DAC (0..0.9 V) plus comparator,
// vin in microvolts, per-cycle expectations from the search definition.
module tb_sar_logic;

  localparam int B = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  longint vin_uv = 0;

  logic comp1, sample1, busy1, done1;
  logic comp2, sample2, busy2, done2;
  logic [7:0] dac1, dout1, dac2, dout2;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    longint     vin;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  // Ideal comparator: vin >= code * 0.9 V / 256.
  assign comp1 = (vin_uv * 256) >= (longint'(dac1) * 900000);
  assign comp2 = (vin_uv * 256) >= (longint'(dac2) * 900000);

  sar_logic dut1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start1),
    .comp_in  (comp1),
    .sample   (sample1),
    .busy     (busy1),
    .dac_code (dac1),
    .data_out (dout1),
    .done     (done1)
  );

  sar_logic #(
    .DAC_BITS      (8),
    .SAMPLE_CYCLES (3),
    .SETTLE_CYCLES (2)
  ) dut2 (
    .clk      (clk),
    .rst      (rst),
    .start    (start2),
    .comp_in  (comp2),
    .sample   (sample2),
    .busy     (busy2),
    .dac_code (dac2),
    .data_out (dout2),
    .done     (done2)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Ideal converter transfer: floor(vin * 256 / 0.9 V), clamped to the code range.
  function automatic int model(input longint v);
    longint r;
    if (v <= 0) return 0;
    r = (v * 256) / 900000;
    if (r > 255) r = 255;
    return int'(r);
  endfunction

  // Expected outputs in cycle c after start was taken (c = 1 is the first SAMPLE cycle).
  function automatic void expect_at(input int c, input int s, input int t, input int res,
                                    output logic es, output logic eb, output logic ed,
                                    output logic [7:0] ec);
    int conv_end;
    int k;
    conv_end = s + B * t;
    es = 1'b0;
    eb = 1'b0;
    ed = 1'b0;
    ec = 8'h00;
    if (c >= 1 && c <= s) begin
      es = 1'b1;
      eb = 1'b1;
    end else if (c > s && c <= conv_end) begin
      // Bits above k are already decided; bit k is the trial.
      k  = B - 1 - (c - s - 1) / t;
      eb = 1'b1;
      ec = 8'(((res >> (k + 1)) << (k + 1)) | (1 << k));
    end else if (c == conv_end + 1) begin
      eb = 1'b1;
      ed = 1'b1;
    end
  endfunction

  task automatic observe(input int which, input string tag, input int c,
                         input logic es, input logic eb, input logic ed,
                         input logic [7:0] ec, input logic [7:0] edata, input bit chk_data);
    logic       os, ob, od;
    logic [7:0] oc, odat;
    os   = which ? sample2 : sample1;
    ob   = which ? busy2 : busy1;
    od   = which ? done2 : done1;
    oc   = which ? dac2 : dac1;
    odat = which ? dout2 : dout1;
    chk($sformatf("%s c%0d sample", tag, c), 32'(os), 32'(es));
    chk($sformatf("%s c%0d busy", tag, c), 32'(ob), 32'(eb));
    chk($sformatf("%s c%0d done", tag, c), 32'(od), 32'(ed));
    chk($sformatf("%s c%0d dac_code", tag, c), 32'(oc), 32'(ec));
    if (chk_data) chk($sformatf("%s c%0d data_out", tag, c), 32'(odat), 32'(edata));
  endtask

  // One full conversion from an idle DUT; entered and left at a negedge.
  task automatic conv(input int which, input longint vin, input bit poke, input string tag);
    int s, t, res, lat;
    logic es, eb, ed;
    logic [7:0] ec;
    s   = which ? 3 : 2;
    t   = which ? 2 : 1;
    res = model(vin);
    lat = 1 + s + B * t;
    vin_uv = vin;
    if (which != 0) start2 = 1'b1;
    else start1 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
      expect_at(c, s, t, res, es, eb, ed, ec);
      observe(which, tag, c, es, eb, ed, ec, 8'(res), c >= lat);
      if (poke && (c == 3 || c == 7)) begin
        if (which != 0) start2 = 1'b1;
        else start1 = 1'b1;
      end
    end
  endtask

  initial begin
    logic es, eb, ed;
    logic [7:0] ec;
    int res;

    tbl[0] = '{450000, 8'h80};
    tbl[1] = '{0, 8'h00};
    tbl[2] = '{900000, 8'hFF};
    tbl[3] = '{100000, 8'h1C};
    tbl[4] = '{-10000, 8'h00};
    tbl[5] = '{898000, 8'hFF};
    tbl[6] = '{3516, 8'h01};

    // Reset values.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst sample1", 32'(sample1), 32'd0);
    chk("rst busy1", 32'(busy1), 32'd0);
    chk("rst done1", 32'(done1), 32'd0);
    chk("rst dac1", 32'(dac1), 32'd0);
    chk("rst dout1", 32'(dout1), 32'd0);
    chk("rst busy2", 32'(busy2), 32'd0);
    chk("rst dac2", 32'(dac2), 32'd0);
    chk("rst dout2", 32'(dout2), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, default timing.
    for (int i = 0; i < 7; i++) begin
      conv(0, tbl[i].vin, 1'b0, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d result", i), 32'(dout1), 32'(tbl[i].exp));
    end

    // Start pulses while busy are dropped.
    conv(0, 450000, 1'b1, "ignore");
    repeat (3) begin
      @(negedge clk);
      chk("ignore idle busy", 32'(busy1), 32'd0);
      chk("ignore no extra done", 32'(done1), 32'd0);
    end

    // Reset mid-CONVERT after a full-scale result.
    conv(0, 900000, 1'b0, "prerst");
    vin_uv = 450000;
    start1 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start1 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", 32'(busy1), 32'd0);
    chk("midrst dac", 32'(dac1), 32'd0);
    chk("midrst data", 32'(dout1), 32'd0);
    chk("midrst sample", 32'(sample1), 32'd0);
    chk("midrst done", 32'(done1), 32'd0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("postrst no done", 32'(done1), 32'd0);
      chk("postrst idle", 32'(busy1), 32'd0);
    end
    conv(0, 450000, 1'b0, "postrst");

    // Slow configuration: 3 sample cycles, 2 settle cycles per bit.
    conv(1, 450000, 1'b0, "slow");
    conv(1, 100000, 1'b0, "slow_lo");

    // start held high: back-to-back conversions, period 12.
    res = model(450000);
    vin_uv = 450000;
    start1 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      expect_at((c - 1) % 12 + 1, 2, 1, res, es, eb, ed, ec);
      observe(0, "b2b", c, es, eb, ed, ec, 8'(res), c >= 11);
      if (c == 35) start1 = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("b2b stops", 32'(busy1), 32'd0);

    // Randomized inputs against the transfer model.
    for (int i = 0; i < 16; i++) begin
      longint v;
      v = longint'($urandom_range(0, 1000000)) - 20000;
      conv(i % 4 == 3 ? 1 : 0, v, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
